// File: rtl/reg_file_pkg.sv
// Register file with save/restore: shared types and reset image.
// Holds the transfer state enum, default reset image and an image slicer.
package reg_file_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } xfer_state_e;

  // Widest image the slicer accepts (W <= 32, 2**D <= 256).
  localparam int IMG_MAX = 8192;

  // r1 = 61, r4 = 255, r5 = 140, all others zero (W=8, D=3).
  localparam logic [63:0] INIT_DEFAULT = {
    8'd0, 8'd0, 8'd140, 8'd255,
    8'd0, 8'd0, 8'd61, 8'd0
  };

  function automatic logic [31:0] img_reg(
    input logic [IMG_MAX-1:0] img,
    input int                 w,
    input int                 i
  );
    logic [IMG_MAX-1:0] s;
    logic [31:0]        m;
    s = img >> (i * w);
    m = (w >= 32) ? 32'hFFFF_FFFF
                  : ((32'd1 << w) - 32'd1);
    return s[31:0] & m;
  endfunction

endpackage

// File: rtl/reg_file_xfer_fsm.sv
// Save/restore sequencer: state, beat index and spill/fill handshakes.
// Outputs the fill write strobe/address/data and the normal-write gate.
module reg_file_xfer_fsm
  import reg_file_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         SaveReq,
  input  logic         RestoreReq,
  input  logic         SpillReady,
  input  logic         FillValid,
  input  logic [W-1:0] FillData,
  output logic         Busy,
  output logic         Done,
  output logic         SpillValid,
  output logic [D-1:0] SpillAddr,
  output logic         FillReady,
  output logic [D-1:0] FillAddr,
  output logic         FillWe,
  output logic [D-1:0] FillWaddr,
  output logic [W-1:0] FillWdata,
  output logic         WriteGate
);

  localparam logic [D-1:0] LAST = '1;

  xfer_state_e state, state_n;
  logic [D-1:0] idx, idx_n;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    Done       = 1'b0;
    SpillValid = 1'b0;
    FillReady  = 1'b0;
    FillWe     = 1'b0;
    unique case (state)
      IDLE: begin
        if (SaveReq) begin
          state_n = SAVE;
          idx_n   = '0;
        end else if (RestoreReq) begin
          state_n = RESTORE;
          idx_n   = '0;
        end
      end
      SAVE: begin
        SpillValid = 1'b1;
        if (SpillReady) begin
          if (idx == LAST) state_n = DONE;
          else idx_n = idx + 1'b1;
        end
      end
      RESTORE: begin
        FillReady = 1'b1;
        if (FillValid) begin
          FillWe = 1'b1;
          if (idx == LAST) state_n = DONE;
          else idx_n = idx + 1'b1;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign Busy      = (state != IDLE);
  assign WriteGate = (state == IDLE);
  assign SpillAddr = idx;
  assign FillAddr  = idx;
  assign FillWaddr = idx;
  assign FillWdata = FillData;

endmodule

// File: rtl/reg_file_spill.sv
// Register file: 2**D x W, NR async read ports, one write, debug tap.
// Save/restore streams the whole set over spill/fill handshakes.
module reg_file_spill
  import reg_file_pkg::*;
#(
  parameter int                   W      = 8,
  parameter int                   D      = 3,
  parameter int                   NR     = 3,
  parameter int                   TAP    = 6,
  parameter bit                   BYPASS = 1'b1,
  parameter logic [W*(2**D)-1:0]  INIT   = INIT_DEFAULT
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         WriteEn,
  input  logic [D-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic [D-1:0] Raddr   [NR],
  output logic [W-1:0] DataOut [NR],
  output logic [W-1:0] Tap,
  input  logic         SaveReq,
  input  logic         RestoreReq,
  output logic         Busy,
  output logic         Done,
  output logic         SpillValid,
  input  logic         SpillReady,
  output logic [D-1:0] SpillAddr,
  output logic [W-1:0] SpillData,
  output logic         FillReady,
  input  logic         FillValid,
  output logic [D-1:0] FillAddr,
  input  logic [W-1:0] FillData
);

  localparam int N = 2 ** D;
  localparam logic [IMG_MAX-1:0] IMG = IMG_MAX'(INIT);
  localparam logic [D-1:0] TAP_IDX = D'(TAP);

  logic [W-1:0] regs [N];
  logic         fill_we;
  logic [D-1:0] fill_addr;
  logic [W-1:0] fill_data;
  logic         wr_gate;
  logic         wr_ok;

  reg_file_xfer_fsm #(
    .W(W),
    .D(D)
  ) u_fsm (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .SaveReq    (SaveReq),
    .RestoreReq (RestoreReq),
    .SpillReady (SpillReady),
    .FillValid  (FillValid),
    .FillData   (FillData),
    .Busy       (Busy),
    .Done       (Done),
    .SpillValid (SpillValid),
    .SpillAddr  (SpillAddr),
    .FillReady  (FillReady),
    .FillAddr   (FillAddr),
    .FillWe     (fill_we),
    .FillWaddr  (fill_addr),
    .FillWdata  (fill_data),
    .WriteGate  (wr_gate)
  );

  // Writes during a transfer are dropped to keep the snapshot whole.
  assign wr_ok = WriteEn && wr_gate;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < N; i++)
        regs[i] <= W'(img_reg(IMG, W, i));
    end else if (fill_we) begin
      regs[fill_addr] <= fill_data;
    end else if (wr_ok) begin
      regs[Waddr] <= DataIn;
    end
  end

  for (genvar p = 0; p < NR; p++) begin : g_rd
    assign DataOut[p] =
      (BYPASS && wr_ok && Raddr[p] == Waddr)
        ? DataIn : regs[Raddr[p]];
  end

  assign Tap       = regs[TAP_IDX];
  assign SpillData = regs[SpillAddr];

endmodule

// File: tb/tb_reg_file_spill.sv
// Directed bench for reg_file_spill (BYPASS=1 and BYPASS=0 instances).
// Each task drives one scenario and checks hand-computed values inline.
module tb_reg_file_spill;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic       WriteEn;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic [2:0] Raddr [3];
  logic [7:0] DataOut [3];
  logic [7:0] DataOut0 [3];
  logic [7:0] Tap, Tap0;
  logic       SaveReq, RestoreReq;
  logic       Busy, Done, SpillValid, FillReady;
  logic       Busy0, Done0, SpillValid0, FillReady0;
  logic       SpillReady, FillValid;
  logic [2:0] SpillAddr, FillAddr, SpillAddr0, FillAddr0;
  logic [7:0] SpillData, SpillData0, FillData;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  reg_file_spill dut (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn),
    .Waddr(Waddr), .DataIn(DataIn), .Raddr(Raddr),
    .DataOut(DataOut), .Tap(Tap), .SaveReq(SaveReq),
    .RestoreReq(RestoreReq), .Busy(Busy), .Done(Done),
    .SpillValid(SpillValid), .SpillReady(SpillReady),
    .SpillAddr(SpillAddr), .SpillData(SpillData),
    .FillReady(FillReady), .FillValid(FillValid),
    .FillAddr(FillAddr), .FillData(FillData)
  );

  reg_file_spill #(.BYPASS(1'b0)) dut0 (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn),
    .Waddr(Waddr), .DataIn(DataIn), .Raddr(Raddr),
    .DataOut(DataOut0), .Tap(Tap0), .SaveReq(SaveReq),
    .RestoreReq(RestoreReq), .Busy(Busy0), .Done(Done0),
    .SpillValid(SpillValid0), .SpillReady(SpillReady),
    .SpillAddr(SpillAddr0), .SpillData(SpillData0),
    .FillReady(FillReady0), .FillValid(FillValid),
    .FillAddr(FillAddr0), .FillData(FillData)
  );

  task automatic set_rd(input int a, input int b, input int c);
    Raddr[0] = 3'(a);
    Raddr[1] = 3'(b);
    Raddr[2] = 3'(c);
  endtask

  task automatic test_reset;
    logic [7:0] e [8];
    e = '{8'd0, 8'd61, 8'd0, 8'd0, 8'd255, 8'd140, 8'd0, 8'd0};
    ResetN = 1'b0;
    WriteEn = 0; Waddr = 0; DataIn = 0;
    SaveReq = 0; RestoreReq = 0;
    SpillReady = 0; FillValid = 0; FillData = 0;
    set_rd(0, 0, 0);
    #12;
    for (int i = 0; i < 8; i++) begin
      set_rd(i, 7 - i, i);
      #1;
      n_cmp++;
      if (DataOut[0] !== e[i] || DataOut[1] !== e[7-i]) begin
        n_bad++;
        $display("FAIL reset_r%0d got %h/%h exp %h/%h",
                 i, DataOut[0], DataOut[1], e[i], e[7-i]);
      end
    end
    n_cmp++;
    if (Tap !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_tap_busy got tap=%h busy=%b done=%b exp 00/0/0",
               Tap, Busy, Done);
    end
    n_cmp++;
    if (SpillValid !== 0 || FillReady !== 0 ||
        SpillAddr !== 0 || FillAddr !== 0) begin
      n_bad++;
      $display("FAIL reset_hs got sv=%b fr=%b sa=%0d fa=%0d exp 0/0/0/0",
               SpillValid, FillReady, SpillAddr, FillAddr);
    end
    @(negedge Clk);
    ResetN = 1'b1;
  endtask

  task automatic test_write_bypass;
    @(posedge Clk); #1;
    WriteEn = 1; Waddr = 3'd6; DataIn = 8'h5A;
    set_rd(6, 6, 6);
    #3;
    for (int p = 0; p < 3; p++) begin
      n_cmp++;
      if (DataOut[p] !== 8'h5A || DataOut0[p] !== 8'h00) begin
        n_bad++;
        $display("FAIL bypass_p%0d got %h/%h exp 5a/00",
                 p, DataOut[p], DataOut0[p]);
      end
    end
    n_cmp++;
    if (Tap !== 8'h00) begin
      n_bad++;
      $display("FAIL tap_pre got %h exp 00", Tap);
    end
    @(posedge Clk); #1;
    WriteEn = 0;
    #1;
    n_cmp++;
    if (DataOut0[0] !== 8'h5A || DataOut0[2] !== 8'h5A ||
        Tap !== 8'h5A || Tap0 !== 8'h5A) begin
      n_bad++;
      $display("FAIL write_after got %h %h tap %h %h exp 5a",
               DataOut0[0], DataOut0[2], Tap, Tap0);
    end
  endtask

  task automatic test_save;
    logic [7:0] e [8];
    int beat, dones;
    bit fin;
    e = '{8'd0, 8'd61, 8'd0, 8'd0, 8'd255, 8'd140, 8'h5A, 8'd0};
    beat = 0; dones = 0; fin = 0;
    @(posedge Clk); #1;
    SaveReq = 1;
    @(posedge Clk); #1;
    SaveReq = 0;
    WriteEn = 1; Waddr = 3'd6; DataIn = 8'hEE;
    SpillReady = 1;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge Clk);
      if (Done) begin
        dones++;
        WriteEn = 0;
      end else if (!Busy) begin
        fin = 1;
      end
      if (SpillValid) begin
        n_cmp++;
        if (beat > 7 || SpillAddr !== 3'(beat) ||
            SpillData !== e[beat & 7] ||
            SpillData0 !== e[beat & 7]) begin
          n_bad++;
          $display("FAIL save_beat%0d got a=%0d d=%h/%h exp a=%0d d=%h",
                   beat, SpillAddr, SpillData, SpillData0,
                   beat, e[beat & 7]);
        end
        if (SpillReady) beat++;
      end
      @(posedge Clk); #1;
      SpillReady = ~SpillReady;
    end
    SpillReady = 0;
    WriteEn = 0;
    n_cmp++;
    if (!fin || beat != 8 || dones != 1 || Busy !== 0) begin
      n_bad++;
      $display("FAIL save_end got fin=%0d beats=%0d dones=%0d busy=%b exp 1/8/1/0",
               fin, beat, dones, Busy);
    end
    set_rd(6, 6, 6);
    #1;
    n_cmp++;
    if (DataOut[0] !== 8'h5A || DataOut0[1] !== 8'h5A) begin
      n_bad++;
      $display("FAIL save_drop_write got %h/%h exp 5a",
               DataOut[0], DataOut0[1]);
    end
  endtask

  task automatic test_restore;
    int beat, dones, bc;
    bit fin;
    beat = 0; dones = 0; bc = 0; fin = 0;
    @(posedge Clk); #1;
    RestoreReq = 1; FillValid = 1; FillData = 8'h10;
    @(posedge Clk); #1;
    RestoreReq = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      @(negedge Clk);
      if (Busy) bc++;
      else fin = 1;
      if (Done) dones++;
      if (FillReady) begin
        n_cmp++;
        if (FillAddr !== 3'(beat) || FillReady0 !== 1'b1) begin
          n_bad++;
          $display("FAIL fill_addr%0d got %0d exp %0d",
                   beat, FillAddr, beat);
        end
        beat++;
      end
      @(posedge Clk); #1;
      FillData = 8'(16 + beat);
    end
    FillValid = 0;
    n_cmp++;
    if (!fin || bc != 9 || dones != 1 || beat != 8) begin
      n_bad++;
      $display("FAIL restore_len got busy=%0d dones=%0d beats=%0d exp 9/1/8",
               bc, dones, beat);
    end
    for (int i = 0; i < 8; i++) begin
      set_rd(i, i, i);
      #1;
      n_cmp++;
      if (DataOut[0] !== 8'(16 + i) || DataOut0[2] !== 8'(16 + i)) begin
        n_bad++;
        $display("FAIL restore_r%0d got %h/%h exp %h",
                 i, DataOut[0], DataOut0[2], 8'(16 + i));
      end
    end
  endtask

  task automatic test_both_req;
    int beats;
    int fr_seen;
    int busy_idle;
    bit fin;
    beats = 0; fr_seen = 0; busy_idle = 0; fin = 0;
    SpillReady = 1;
    @(posedge Clk); #1;
    SaveReq = 1; RestoreReq = 1;
    @(posedge Clk); #1;
    SaveReq = 0; RestoreReq = 0;
    @(negedge Clk);
    n_cmp++;
    if (SpillValid !== 1'b1 || FillReady !== 1'b0) begin
      n_bad++;
      $display("FAIL both_req got sv=%b fr=%b exp 1/0",
               SpillValid, FillReady);
    end
    beats = 1;
    @(posedge Clk); #1;
    RestoreReq = 1;
    for (int c = 0; c < 30 && !fin; c++) begin
      @(negedge Clk);
      if (c == 1) RestoreReq = 0;
      if (!Busy) fin = 1;
      if (SpillValid) beats++;
      if (FillReady) fr_seen++;
      @(posedge Clk); #1;
    end
    RestoreReq = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      if (Busy) busy_idle++;
    end
    SpillReady = 0;
    n_cmp++;
    if (!fin || beats != 8 || fr_seen != 0 || busy_idle != 0) begin
      n_bad++;
      $display("FAIL busy_ignore got fin=%0d beats=%0d fill=%0d busy=%0d exp 1/8/0/0",
               fin, beats, fr_seen, busy_idle);
    end
  endtask

  task automatic test_reset_mid_restore;
    int beat, dones, busys;
    beat = 0; dones = 0; busys = 0;
    set_rd(0, 1, 3);
    @(posedge Clk); #1;
    RestoreReq = 1; FillValid = 1; FillData = 8'hC0;
    @(posedge Clk); #1;
    RestoreReq = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      @(negedge Clk);
      if (FillReady) beat++;
      if (beat < 4) begin
        @(posedge Clk); #1;
        FillData = 8'(8'hC0 + beat);
      end
    end
    @(posedge Clk); #2;
    n_cmp++;
    if (beat != 4 || DataOut[2] !== 8'hC3) begin
      n_bad++;
      $display("FAIL mid_restore got beats=%0d r3=%h exp 4/c3",
               beat, DataOut[2]);
    end
    ResetN = 0;
    #1;
    n_cmp++;
    if (DataOut[0] !== 8'd0 || DataOut[1] !== 8'd61 ||
        DataOut[2] !== 8'd0 || DataOut0[1] !== 8'd61) begin
      n_bad++;
      $display("FAIL mid_reset_regs got %h %h %h exp 00 3d 00",
               DataOut[0], DataOut[1], DataOut[2]);
    end
    n_cmp++;
    if (Busy !== 0 || FillReady !== 0 || FillAddr !== 0 || Done !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_ctl got busy=%b fr=%b fa=%0d done=%b exp 0/0/0/0",
               Busy, FillReady, FillAddr, Done);
    end
    @(posedge Clk); #1;
    ResetN = 1;
    FillValid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (Done) dones++;
      if (Busy) busys++;
    end
    n_cmp++;
    if (dones != 0 || busys != 0) begin
      n_bad++;
      $display("FAIL mid_reset_after got dones=%0d busy=%0d exp 0/0",
               dones, busys);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_save();
    test_restore();
    test_both_req();
    test_reset_mid_restore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_spill.md
# reg_file_spill

Parametrised successor to the CPU register file. Holds 2**D registers of W bits with NR combinational read ports, one write port, optional write-through bypass and a fixed debug tap. Adds a save/restore sequencer that streams the whole register set out to, or back in from, an external memory over valid/ready handshakes, for context switch and debug snapshot. Sits between the decode/execute stage and the data-memory arbiter.

## Interface
- W, 8, data width
- D, 3, address width; 2**D registers
- NR, 3, number of read ports (1..8)
- TAP, 6, register index driven on Tap
- BYPASS, 1, 1 = read of Waddr during an accepted write returns DataIn in the same cycle
- INIT, reg_file_pkg::INIT_DEFAULT, packed W*2**D reset image; default is all zero except r1=61, r4=2**W-1, r5=140
- Clk  in  1  clock; all state updates on the rising edge
- ResetN  in  1  asynchronous, active-low reset
- WriteEn  in  1  normal write strobe
- Waddr  in  D  write address
- DataIn  in  W  write data
- Raddr  in  NR×D  read addresses, unpacked per port
- DataOut  out  NR×W  read data, combinational
- Tap  out  W  contents of register TAP
- SaveReq / RestoreReq  in  1  start save / restore; sampled only in IDLE
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle completion pulse
- SpillValid  out  1; SpillReady  in  1; SpillAddr  out  D; SpillData  out  W  save stream
- FillReady  out  1; FillValid  in  1; FillAddr  out  D; FillData  in  W  restore stream

## Operation
- Reset (ResetN=0, any time, mid-transfer included): registers = INIT; state IDLE; index = 0; Busy, Done, SpillValid, FillReady = 0; SpillAddr = FillAddr = 0.
- FSM states IDLE, SAVE, RESTORE, DONE.
- IDLE: accepted write when WriteEn=1. SaveReq=1 goes to SAVE. RestoreReq=1 alone goes to RESTORE. If both are high, SAVE wins. Index is cleared on entry.
- SAVE: SpillValid=1, SpillAddr=index, SpillData=Registers[index]. A beat completes on SpillValid&&SpillReady and increments index. The beat at index 2**D-1 goes to DONE. SpillData must hold stable while Ready is low.
- RESTORE: FillReady=1, FillAddr=index. On FillValid&&FillReady, Registers[index] <= FillData and index increments. The beat at 2**D-1 goes to DONE.
- DONE: Done=1 for one cycle, then IDLE.
- While Busy, WriteEn is ignored and the write is dropped, not queued; this keeps the snapshot consistent. SaveReq and RestoreReq are ignored while Busy.
- Read ports stay live in all states. During RESTORE they show partially restored contents.
- Bypass applies only to accepted normal writes, never to fill writes. With BYPASS=0, reads show the old value until the edge.
- Index width is D; wrap is never reached because the terminal beat exits the state.

## Timing
- Reads and Tap: combinational, zero latency. Writes: visible after the next rising edge.
- Request sampled at edge n gives Busy=1 from cycle n+1.
- With Ready or Valid held high, the transfer takes 2**D beats in cycles n+1..n+2**D, Done in cycle n+2**D+1, and IDLE from n+2**D+2.
- A new request is accepted earliest in the first IDLE cycle, so the gap between transfers is at least 1 cycle.

## Structure
- reg_file_pkg contains:
  - the state enum typedef (IDLE, SAVE, RESTORE, DONE)
  - the INIT_DEFAULT constant
  - a function that extracts register i from a packed image
- Sub-module reg_file_xfer_fsm owns the state, the index counter and the handshake outputs. It supplies the fill-write enable, address and data, plus the WriteEn gate, to the storage array in the top level.

## Test plan
- Reset with defaults → read r1=61, r4=255, r5=140, others 0; Tap=0; Busy=0.
- Write r6=0x5A, then read it on all NR ports in the same cycle → BYPASS=1 returns 0x5A that cycle; BYPASS=0 returns the old value, then 0x5A next cycle; Tap=0x5A.
- SaveReq with SpillReady toggling 1,0,1,… → 8 beats with addr 0..7 in order and data stable while stalled. Done pulses once, Busy falls after Done. A WriteEn during SAVE leaves the register unchanged.
- RestoreReq, FillData=0x10+addr, FillValid always high → Busy for 9 cycles; afterwards ri reads 0x10+i.
- SaveReq and RestoreReq asserted together → SAVE taken; RestoreReq issued while Busy is ignored.
- ResetN pulsed low at beat 4 of a RESTORE → registers return to INIT immediately, IDLE, FillReady=0, no Done pulse.
